// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, derived totals, coordinate and
// colour widths, and a window-decode helper used by the raster timing block.
package vga_pkg;

  localparam int unsigned HDisplay = 640;
  localparam int unsigned HFront   = 16;
  localparam int unsigned HSync    = 96;
  localparam int unsigned HBack    = 48;
  localparam int unsigned VDisplay = 480;
  localparam int unsigned VFront   = 10;
  localparam int unsigned VSync    = 2;
  localparam int unsigned VBack    = 33;

  localparam int unsigned HTotal = HDisplay + HFront + HSync + HBack;
  localparam int unsigned VTotal = VDisplay + VFront + VSync + VBack;

  localparam int unsigned CoordW = 10;
  localparam int unsigned ColorW = 6;

  typedef logic [CoordW-1:0] coord_t;
  typedef logic [ColorW-1:0] color_t;

  // True when lo <= pos < lo + len.
  function automatic logic in_window(coord_t pos, int unsigned lo, int unsigned len);
    logic [31:0] p;
    p = 32'(pos);
    return (p >= lo) && (p < lo + len);
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-latency shift register with asynchronous active-high reset.
//   clk, rst : clock and reset (reset loads RESET_VALUE into every stage)
//   data_i   : input word
//   data_o   : data_i delayed by DEPTH clocks
//   prev_o   : data_i delayed by DEPTH-1 clocks (data_i itself when DEPTH is 1)
module pipe_delay #(
  parameter int unsigned     WIDTH       = 1,
  parameter int unsigned     DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] prev_o
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = data_i;
    for (int i = 1; i < int'(DEPTH); i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= {DEPTH{RESET_VALUE}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign data_o = stage_q[DEPTH-1];

  if (DEPTH == 1) begin : g_prev_direct
    assign prev_o = data_i;
  end else begin : g_prev_stage
    assign prev_o = stage_q[DEPTH-2];
  end

endmodule

// File: rtl/vga_timing.sv
// Raster timing and output stage.
//   clk, rst     : pixel clock, asynchronous active-high reset
//   hpos, vpos   : current raster coordinate
//   frame        : frame counter, increments when the raster wraps to (0,0)
//   line_start   : hpos == 0;  frame_start : hpos == 0 and vpos == 0
//   rrggbb_in    : upstream colour, valid PIPE_DEPTH-1 clocks after its coordinate
//   hsync, vsync : sync pulses delayed PIPE_DEPTH clocks, polarity from SYNC_NEG
//   display_on   : visible-area flag delayed PIPE_DEPTH clocks
//   rrggbb       : registered colour, zero outside the visible area
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_DISPLAY  = HDisplay,
  parameter int unsigned H_FRONT    = HFront,
  parameter int unsigned H_SYNC     = HSync,
  parameter int unsigned H_BACK     = HBack,
  parameter int unsigned V_DISPLAY  = VDisplay,
  parameter int unsigned V_FRONT    = VFront,
  parameter int unsigned V_SYNC     = VSync,
  parameter int unsigned V_BACK     = VBack,
  parameter bit          SYNC_NEG   = 1'b1,
  parameter int unsigned PIPE_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [CoordW-1:0] hpos,
  output logic [CoordW-1:0] vpos,
  output logic [15:0]       frame,
  output logic              line_start,
  output logic              frame_start,
  input  logic [ColorW-1:0] rrggbb_in,
  output logic              hsync,
  output logic              vsync,
  output logic              display_on,
  output logic [ColorW-1:0] rrggbb
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam coord_t      HMax    = coord_t'(H_TOTAL - 1);
  localparam coord_t      VMax    = coord_t'(V_TOTAL - 1);

  coord_t      hpos_q, hpos_d;
  coord_t      vpos_q, vpos_d;
  logic [15:0] frame_q, frame_d;
  color_t      rrggbb_q, rrggbb_d;

  always_comb begin
    hpos_d  = hpos_q + 1'b1;
    vpos_d  = vpos_q;
    frame_d = frame_q;
    if (hpos_q == HMax) begin
      hpos_d = '0;
      if (vpos_q == VMax) begin
        vpos_d  = '0;
        frame_d = frame_q + 1'b1;
      end else begin
        vpos_d = vpos_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hpos_q  <= '0;
      vpos_q  <= '0;
      frame_q <= '0;
    end else begin
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      frame_q <= frame_d;
    end
  end

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign frame       = frame_q;
  assign line_start  = (hpos_q == '0);
  assign frame_start = (hpos_q == '0) && (vpos_q == '0);

  // Stage-0 decode, bit order {hs_act, vs_act, vis}.
  logic [2:0] raw, dly, dly_prev;

  always_comb begin
    raw[2] = in_window(hpos_q, H_DISPLAY + H_FRONT, H_SYNC);
    raw[1] = in_window(vpos_q, V_DISPLAY + V_FRONT, V_SYNC);
    raw[0] = (32'(hpos_q) < H_DISPLAY) && (32'(vpos_q) < V_DISPLAY);
  end

  pipe_delay #(
    .WIDTH      (3),
    .DEPTH      (PIPE_DEPTH),
    .RESET_VALUE(3'b000)
  ) u_sync_delay (
    .clk   (clk),
    .rst   (rst),
    .data_i(raw),
    .data_o(dly),
    .prev_o(dly_prev)
  );

  // The colour register is the final stage, so it gates with vis one stage early.
  always_comb begin
    rrggbb_d = dly_prev[0] ? rrggbb_in : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrggbb_q <= '0;
    end else begin
      rrggbb_q <= rrggbb_d;
    end
  end

  assign hsync      = dly[2] ^ SYNC_NEG;
  assign vsync      = dly[1] ^ SYNC_NEG;
  assign display_on = dly[0];
  assign rrggbb     = rrggbb_q;

endmodule
